// File: rtl/fcpu_pkg.sv
// fcpu_pkg: shared types and constants for serial_dram_cmd.
//   - state_e     : sequencer states (S_ACK exists only when the
//                   SERIAL_DRAM_CMD_WRITE_ACK_EN macro is defined)
//   - OPC_*       : host opcode bytes
//   - ACK_BYTE    : byte returned after a completed write (ACK build)
//   - APP_CMD_*   : DDR3 controller app_cmd encodings
package fcpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_DATA     = 3'd2,
    S_WR_ISSUE = 3'd3,
    S_RD_ISSUE = 3'd4,
    S_RD_WAIT  = 3'd5,
    S_TX       = 3'd6
`ifdef SERIAL_DRAM_CMD_WRITE_ACK_EN
    ,S_ACK     = 3'd7
`endif
  } state_e;

  localparam logic [7:0] OPC_WRITE  = 8'h57;
  localparam logic [7:0] OPC_READ   = 8'h52;
  localparam logic [7:0] ACK_BYTE   = 8'h4B;
  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

endpackage

// File: rtl/serial_dram_cmd.sv
// serial_dram_cmd: byte-stream command parser / sequencer in front of the
// DDR3 controller app interface (ui_clk domain).
//   Host protocol (MSB first):
//     'W' A3 A2 A1 A0 D3 D2 D1 D0 -> write 32-bit word at byte address A
//     'R' A3 A2 A1 A0             -> read; reply D3 D2 D1 D0 on tx
//   Ports:
//     ui_clk, sys_rst (sync, active-low), init_calib_complete
//     rx_data/rx_valid/rx_ready      : inbound byte stream
//     tx_data/tx_valid/tx_ready      : outbound byte stream
//     app_addr/app_cmd/app_en/app_rdy: controller command channel
//     app_wdf_data/wren/end/mask/rdy : controller write data channel
//     app_rd_data/app_rd_data_valid  : controller read return
//     busy                           : sequencer not idle
//   Build option: define SERIAL_DRAM_CMD_WRITE_ACK_EN to return 'K' (0x4B)
//   on tx after every completed write.
module serial_dram_cmd
  import fcpu_pkg::*;
#(
  parameter int APP_ADDR_W = 28,
  parameter int APP_DATA_W = 128,
  parameter int APP_MASK_W = 16
) (
  input  logic                  ui_clk,
  input  logic                  sys_rst,
  input  logic                  init_calib_complete,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [APP_ADDR_W-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [APP_DATA_W-1:0] app_wdf_data,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [APP_MASK_W-1:0] app_wdf_mask,
  input  logic                  app_wdf_rdy,
  input  logic [APP_DATA_W-1:0] app_rd_data,
  input  logic                  app_rd_data_valid,
  output logic                  busy
);

  // Burst-aligned controller address (16-bit units) for a byte address.
  function automatic logic [APP_ADDR_W-1:0] map_addr(input logic [31:0] a);
    return {a[APP_ADDR_W:4], 3'b000};
  endfunction

  // Enable only the four byte lanes of the addressed 32-bit word.
  function automatic logic [APP_MASK_W-1:0] lane_mask(input logic [1:0] lane);
    logic [APP_MASK_W-1:0] m;
    m = '1;
    m[{lane, 2'b00} +: 4] = 4'b0000;
    return m;
  endfunction

  state_e                state_q, state_d;
  logic                  is_wr_q, is_wr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  app_en_q, app_en_d;
  logic [2:0]            app_cmd_q, app_cmd_d;
  logic [APP_ADDR_W-1:0] app_addr_q, app_addr_d;
  logic [APP_DATA_W-1:0] wdf_data_q, wdf_data_d;
  logic [APP_MASK_W-1:0] wdf_mask_q, wdf_mask_d;
  logic                  wren_q, wren_d;
  logic                  busy_q, busy_d;
  logic                  rx_ready_s;
  logic [31:0]           addr_next_s, data_next_s, rd_word_s;
  logic                  unused_addr_s;

  // Address bits above the controller range and below the word are unused.
  assign unused_addr_s = ^{addr_q[31:APP_ADDR_W+1], addr_q[1:0]};

  // rx_ready is decoded from the registered state; gated off during reset.
  assign rx_ready     = rx_ready_s & sys_rst;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign app_addr     = app_addr_q;
  assign app_cmd      = app_cmd_q;
  assign app_en       = app_en_q;
  assign app_wdf_data = wdf_data_q;
  assign app_wdf_wren = wren_q;
  assign app_wdf_end  = wren_q;
  assign app_wdf_mask = wdf_mask_q;
  assign busy         = busy_q;

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    app_en_d    = app_en_q;
    app_cmd_d   = app_cmd_q;
    app_addr_d  = app_addr_q;
    wdf_data_d  = wdf_data_q;
    wdf_mask_d  = wdf_mask_q;
    wren_d      = wren_q;
    rx_ready_s  = 1'b0;
    addr_next_s = {addr_q[23:0], rx_data};
    data_next_s = {data_q[23:0], rx_data};
    rd_word_s   = app_rd_data[{addr_q[3:2], 5'b00000} +: 32];

    case (state_q)
      S_IDLE: begin
        rx_ready_s = init_calib_complete;
        // Unknown opcodes are consumed here and simply not acted on.
        if (rx_valid && init_calib_complete &&
            (rx_data == OPC_WRITE || rx_data == OPC_READ)) begin
          is_wr_d = (rx_data == OPC_WRITE);
          cnt_d   = 2'd0;
          state_d = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        rx_ready_s = 1'b1;
        if (rx_valid) begin
          addr_d = addr_next_s;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (is_wr_q) begin
              state_d = S_DATA;
            end else begin
              state_d    = S_RD_ISSUE;
              app_en_d   = 1'b1;
              app_cmd_d  = APP_CMD_RD;
              app_addr_d = map_addr(addr_next_s);
            end
          end else begin
            state_d = S_ADDR;
          end
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        rx_ready_s = 1'b1;
        if (rx_valid) begin
          data_d = data_next_s;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d    = S_WR_ISSUE;
            app_en_d   = 1'b1;
            wren_d     = 1'b1;
            app_cmd_d  = APP_CMD_WR;
            app_addr_d = map_addr(addr_q);
            wdf_data_d = {4{data_next_s}};
            wdf_mask_d = lane_mask(addr_q[3:2]);
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_WR_ISSUE: begin
        // Command and data channels complete independently.
        if (app_en_q && app_rdy) begin
          app_en_d = 1'b0;
        end else begin
          app_en_d = app_en_q;
        end
        if (wren_q && app_wdf_rdy) begin
          wren_d = 1'b0;
        end else begin
          wren_d = wren_q;
        end
        if ((!app_en_q || app_rdy) && (!wren_q || app_wdf_rdy)) begin
`ifdef SERIAL_DRAM_CMD_WRITE_ACK_EN
          state_d    = S_ACK;
          tx_valid_d = 1'b1;
          tx_data_d  = ACK_BYTE;
`else
          state_d    = S_IDLE;
`endif
        end else begin
          state_d = S_WR_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        if (app_rdy) begin
          app_en_d = 1'b0;
          state_d  = S_RD_WAIT;
        end else begin
          state_d  = S_RD_ISSUE;
        end
      end
      S_RD_WAIT: begin
        // First reply byte goes out directly; the rest is kept left-aligned.
        if (app_rd_data_valid) begin
          tx_valid_d = 1'b1;
          tx_data_d  = rd_word_s[31:24];
          data_d     = {rd_word_s[23:0], 8'h00};
          cnt_d      = 2'd0;
          state_d    = S_TX;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_TX: begin
        if (tx_ready) begin
          if (cnt_q == 2'd3) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            tx_data_d = data_q[31:24];
            data_d    = {data_q[23:0], 8'h00};
            cnt_d     = cnt_q + 2'd1;
            state_d   = S_TX;
          end
        end else begin
          state_d = S_TX;
        end
      end
`ifdef SERIAL_DRAM_CMD_WRITE_ACK_EN
      S_ACK: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_ACK;
        end
      end
`endif
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        app_en_d   = 1'b0;
        wren_d     = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge ui_clk) begin
    if (!sys_rst) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      cnt_q      <= 2'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'd0;
      app_en_q   <= 1'b0;
      app_cmd_q  <= 3'b000;
      app_addr_q <= '0;
      wdf_data_q <= '0;
      wdf_mask_q <= '1;
      wren_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      app_en_q   <= app_en_d;
      app_cmd_q  <= app_cmd_d;
      app_addr_q <= app_addr_d;
      wdf_data_q <= wdf_data_d;
      wdf_mask_q <= wdf_mask_d;
      wren_q     <= wren_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_serial_dram_cmd.sv
// Directed bench for serial_dram_cmd with a small DDR3 app-interface model
// and scoreboard queues for controller commands, write data and tx bytes.
module tb_serial_dram_cmd;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = 16;

  logic          ui_clk = 1'b0;
  logic          sys_rst;
  logic          init_calib_complete;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic [MW-1:0] app_wdf_mask;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          busy;

  always #5 ui_clk = ~ui_clk;

  serial_dram_cmd #(.APP_ADDR_W(AW), .APP_DATA_W(DW), .APP_MASK_W(MW)) dut (
    .ui_clk(ui_clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid), .busy(busy)
  );

  int checks = 0;
  int fails  = 0;

  logic [30:0]  cmdq[$];          // {app_cmd, app_addr}
  logic [143:0] wrq[$];           // {wdf_data, wdf_mask}
  logic [7:0]   txq[$];
  logic [127:0] mem[logic [27:0]];
  logic [31:0]  ref_word[int];

  bit           tx_toggle = 1'b0;
  bit           rd_pend = 1'b0;
  int           rd_delay = 0;
  logic [27:0]  rd_addr;
  bit           resp_expected = 1'b0;
  bit           lat_chk = 1'b0;
  bit           hold_prev = 1'b0;
  logic [7:0]   hold_data;
  int           en_cycles = 0;
  int           wren_cycles = 0;
  int           cmd_hs = 0;
  int           end_bad = 0;
  bit           wr_a_ok = 1'b0;
  bit           wr_d_ok = 1'b0;
  logic [27:0]  wr_addr;
  logic [127:0] wr_d;
  logic [15:0]  wr_m;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] amap(input logic [31:0] a);
    return {a[28:4], 3'b000};
  endfunction

  function automatic logic [15:0] lmask(input logic [31:0] a);
    logic [15:0] m;
    m = 16'hFFFF;
    m[a[3:2]*4 +: 4] = 4'b0000;
    return m;
  endfunction

  // DDR3 controller model plus output monitor (drive at negedge, sample 1 ns later).
  initial begin
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    tx_ready = 1'b1;
    forever begin
      @(negedge ui_clk);
      app_rd_data_valid = 1'b0;
      if (tx_toggle) tx_ready = ~tx_ready; else tx_ready = 1'b1;
      if (rd_pend) begin
        if (rd_delay == 0) begin
          app_rd_data_valid = 1'b1;
          app_rd_data = mem.exists(rd_addr) ? mem[rd_addr] : 128'd0;
          rd_pend = 1'b0;
          resp_expected = (txq.size() != 0);
        end else begin
          rd_delay--;
        end
      end
      #1;
      if (lat_chk) begin
        check("rd_to_tx_latency", tx_valid, 1'b1);
        lat_chk = 1'b0;
      end
      if (app_rd_data_valid && resp_expected) lat_chk = 1'b1;
      if (hold_prev) check("tx_hold", {tx_valid, tx_data}, {1'b1, hold_data});
      hold_prev = tx_valid && !tx_ready;
      hold_data = tx_data;
      if (tx_valid && tx_ready) begin
        if (txq.size() != 0) check("tx_byte", {1'b1, tx_data}, {1'b1, txq.pop_front()});
        else check("tx_unexpected", {1'b1, tx_data}, 9'h000);
      end
      if (app_en) en_cycles++;
      if (app_wdf_wren) wren_cycles++;
      if (app_wdf_end !== app_wdf_wren) end_bad++;
      if (app_en && app_rdy) begin
        cmd_hs++;
        if (cmdq.size() != 0) check("app_cmd_addr", {1'b1, app_cmd, app_addr}, {1'b1, cmdq.pop_front()});
        else check("app_cmd_unexpected", {1'b1, app_cmd, app_addr}, 32'd0);
        if (app_cmd == 3'b001) begin
          rd_pend = 1'b1;
          rd_delay = 19;
          rd_addr = app_addr;
        end else begin
          wr_addr = app_addr;
          wr_a_ok = 1'b1;
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        if (wrq.size() != 0) begin
          logic [143:0] e;
          e = wrq.pop_front();
          check("wdf_data", app_wdf_data, e[143:16]);
          check("wdf_mask", app_wdf_mask, e[15:0]);
        end else begin
          check("wdf_unexpected", 1'b0, 1'b1 & app_wdf_wren);
        end
        wr_d = app_wdf_data;
        wr_m = app_wdf_mask;
        wr_d_ok = 1'b1;
      end
      if (wr_a_ok && wr_d_ok) begin
        logic [127:0] line;
        line = mem.exists(wr_addr) ? mem[wr_addr] : 128'd0;
        for (int b = 0; b < 16; b++) if (!wr_m[b]) line[8*b +: 8] = wr_d[8*b +: 8];
        mem[wr_addr] = line;
        wr_a_ok = 1'b0;
        wr_d_ok = 1'b0;
      end
    end
  end

  // Present one byte at a negedge and hold it until accepted; returns at a negedge.
  task automatic send_byte(input logic [7:0] b);
    bit acc;
    acc = 1'b0;
    rx_data = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      #1;
      acc = rx_ready;
      @(negedge ui_clk);
    end
    rx_valid = 1'b0;
    if (!acc) check("rx_accept_timeout", acc, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge ui_clk);
      #1;
      ok = !busy && (txq.size() == 0) && !rd_pend;
    end
    check(tag, ok, 1'b1);
    repeat (2) @(negedge ui_clk);
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    cmdq.push_back({3'b000, amap(a)});
    wrq.push_back({{4{d}}, lmask(a)});
    ref_word[int'(a >> 2)] = d;
`ifdef SERIAL_DRAM_CMD_WRITE_ACK_EN
    txq.push_back(8'h4B);
`endif
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    expect_write(a, d);
    send_byte(8'h57);
    send_word(a);
    send_word(d);
    wait_idle("write_done");
  endtask

  task automatic do_read(input logic [31:0] a);
    logic [31:0] w;
    w = ref_word.exists(int'(a >> 2)) ? ref_word[int'(a >> 2)] : 32'd0;
    cmdq.push_back({3'b001, amap(a)});
    for (int i = 3; i >= 0; i--) txq.push_back(w[8*i +: 8]);
    send_byte(8'h52);
    send_word(a);
    wait_idle("read_done");
  endtask

  task automatic pulse_reset(input int n);
    rx_valid = 1'b0;
    sys_rst = 1'b0;
    repeat (n) @(negedge ui_clk);
    sys_rst = 1'b1;
  endtask

  initial begin
    bit stable;
    int hs0;
    sys_rst = 1'b0;
    init_calib_complete = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;

    // Reset values.
    repeat (3) @(negedge ui_clk);
    #1;
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_app_en", app_en, 1'b0);
    check("rst_wren", app_wdf_wren, 1'b0);
    check("rst_app_cmd", app_cmd, 3'b000);
    check("rst_app_addr", app_addr, 28'd0);
    check("rst_wdf_data", app_wdf_data, 128'd0);
    check("rst_wdf_mask", app_wdf_mask, 16'hFFFF);
    check("rst_busy", busy, 1'b0);

    // Calibration gating: a valid 'W' must not be consumed.
    @(negedge ui_clk);
    sys_rst = 1'b1;
    rx_data = 8'h57;
    rx_valid = 1'b1;
    repeat (3) @(negedge ui_clk);
    #1;
    check("calib_rx_ready", rx_ready, 1'b0);
    check("calib_busy", busy, 1'b0);
    @(negedge ui_clk);
    rx_valid = 1'b0;
    init_calib_complete = 1'b1;
    @(negedge ui_clk);
    #1;
    check("idle_rx_ready", rx_ready, 1'b1);
    @(negedge ui_clk);

    // Junk opcode is dropped, then a normal write with single-cycle pulses.
    send_byte(8'h41);
    #1;
    check("junk_busy", busy, 1'b0);
    @(negedge ui_clk);
    en_cycles = 0;
    wren_cycles = 0;
    cmd_hs = 0;
    do_write(32'h0000_0014, 32'hDEAD_BEEF);
    check("wr_en_cycles", en_cycles, 1);
    check("wr_wren_cycles", wren_cycles, 1);
    check("wr_cmd_count", cmd_hs, 1);

    // Read back.
    do_read(32'h0000_0014);

    // Backpressure: app_rdy low 5 cycles, wdf_rdy low 9 cycles.
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    expect_write(32'h0000_0028, 32'h1234_5678);
    send_byte(8'h57);
    send_word(32'h0000_0028);
    send_word(32'h1234_5678);
    en_cycles = 0;
    wren_cycles = 0;
    hs0 = cmd_hs;
    stable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (app_en && (app_addr !== 28'h000_0010 || app_cmd !== 3'b000)) stable = 1'b0;
      if (app_wdf_wren && (app_wdf_data !== {4{32'h1234_5678}} || app_wdf_mask !== 16'hF0FF)) stable = 1'b0;
      app_rdy = (i >= 5);
      app_wdf_rdy = (i >= 9);
      @(negedge ui_clk);
    end
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    wait_idle("bp_done");
    check("bp_en_cycles", en_cycles, 6);
    check("bp_wren_cycles", wren_cycles, 10);
    check("bp_payload_stable", stable, 1'b1);
    check("bp_cmd_count", cmd_hs - hs0, 1);

    // Another word in the same burst line, then reads with tx backpressure.
    do_write(32'h0000_002C, 32'hCAFE_F00D);
    tx_toggle = 1'b1;
    do_read(32'h0000_0028);
    do_read(32'h0000_002C);
    tx_toggle = 1'b0;

    // Reset after two address bytes, then a clean read.
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h00);
    pulse_reset(2);
    do_read(32'h0000_0014);

    // Reset while a read is outstanding: the late response is ignored.
    cmdq.push_back({3'b001, amap(32'h0000_0014)});
    send_byte(8'h52);
    send_word(32'h0000_0014);
    repeat (2) @(negedge ui_clk);
    pulse_reset(2);
    repeat (40) @(negedge ui_clk);
    #1;
    check("stale_tx_valid", tx_valid, 1'b0);
    check("stale_busy", busy, 1'b0);
    @(negedge ui_clk);
    do_read(32'h0000_002C);

    check("wdf_end_tied", end_bad, 0);
    check("cmd_queue_drained", cmdq.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
